sudoku_status_display: RTL



---
 rtl/sudoku_status_display.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sudoku_status_display.sv
// Board-status front panel for the Sudoku solver.
// Shows the solver run state with a spinner while working.
// Latches the cursor on a key edge and cycles the occupancy-mask view shown on the LEDs.
module sudoku_status_display #(
  parameter int GRID_ORDER = 3,
  parameter int TICK_DIV   = 12500000,
  localparam int LEN       = GRID_ORDER * GRID_ORDER,
  localparam int POS_W     = $clog2(LEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             done,
  input  logic             success,
  input  logic [POS_W-1:0] cursor_row,
  input  logic [POS_W-1:0] cursor_col,
  input  logic             snap_key,
  input  logic             mode_key,
  input  logic [LEN-1:0]   occ_row,
  input  logic [LEN-1:0]   occ_col,
  input  logic [LEN-1:0]   occ_blk,
  output logic [1:0]       view_mode,
  output logic [LEN-1:0]   ledr,
  output logic [6:0]       hex_status,
  output logic [6:0]       hex_row,
  output logic [6:0]       hex_col
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_PASS = 7'b0010010;
  localparam logic [6:0] SEG_FAIL = 7'b0001110;

  if (GRID_ORDER < 2 || GRID_ORDER > 4) begin : g_bad_order
    $error("sudoku_status_display: GRID_ORDER must be 2, 3 or 4");
  end
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("sudoku_status_display: TICK_DIV must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t state_q, state_d;
  logic   fresh_q;
  logic [TICK_W-1:0] tick_q;
  logic [2:0] spin_q;
  logic [2:0] snap_sync_q, mode_sync_q;
  logic       snap_act_q, mode_act_q;
  logic [POS_W-1:0] row_q, col_q;
  logic [1:0] mode_q;
  logic [LEN-1:0] ledr_q;
  logic [6:0] status_q;

  // Hex glyph for one nibble, active-low {g..a}.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Single lit outer segment for each spinner step, a around to f.
  function automatic logic [6:0] spin_seg(input logic [2:0] i);
    case (i)
      3'd0: spin_seg = 7'b1111110;
      3'd1: spin_seg = 7'b1111101;
      3'd2: spin_seg = 7'b1111011;
      3'd3: spin_seg = 7'b1110111;
      3'd4: spin_seg = 7'b1101111;
      3'd5: spin_seg = 7'b1011111;
      default: spin_seg = 7'b1111111;
    endcase
  endfunction

  // Run-state transitions. A start always (re)enters RUN; done is ignored on the first RUN cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (start)                state_d = RUN;
        else if (!fresh_q && done) state_d = success ? PASS : FAIL;
      end
      PASS, FAIL: begin
        if (start)      state_d = RUN;
        else if (!done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus a flag marking the first cycle after RUN entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fresh_q <= start;
    end
  end

  // Spinner timebase: counts only while running, restarted by every start.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tick_q <= '0;
      spin_q <= '0;
    end else if (start) begin
      tick_q <= '0;
      spin_q <= '0;
    end else if (state_q == RUN) begin
      if (tick_q == TICK_MAX) begin
        tick_q <= '0;
        spin_q <= (spin_q == 3'd5) ? 3'd0 : spin_q + 3'd1;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
    end
  end

  // Registered status digit derived from the current state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      status_q <= SEG_DASH;
    end else begin
      case (state_q)
        RUN:     status_q <= spin_seg(spin_q);
        PASS:    status_q <= SEG_PASS;
        FAIL:    status_q <= SEG_FAIL;
        default: status_q <= SEG_DASH;
      endcase
    end
  end

  // Two-flop synchronizers for both keys, then a registered rising-edge pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      snap_sync_q <= '0;
      mode_sync_q <= '0;
      snap_act_q  <= 1'b0;
      mode_act_q  <= 1'b0;
    end else begin
      snap_sync_q <= {snap_sync_q[1:0], snap_key};
      mode_sync_q <= {mode_sync_q[1:0], mode_key};
      snap_act_q  <= snap_sync_q[1] & ~snap_sync_q[2];
      mode_act_q  <= mode_sync_q[1] & ~mode_sync_q[2];
    end
  end

  // Cursor latch on a snap action.
  always_ff @(posedge clock) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (snap_act_q) begin
      row_q <= cursor_row;
      col_q <= cursor_col;
    end
  end

  // View mode steps row -> col -> blk -> row; the unused code falls back to row.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_q <= 2'd0;
    end else if (mode_act_q) begin
      case (mode_q)
        2'd0:    mode_q <= 2'd1;
        2'd1:    mode_q <= 2'd2;
        default: mode_q <= 2'd0;
      endcase
    end else if (mode_q == 2'd3) begin
      mode_q <= 2'd0;
    end
  end

  // Registered LED mask for the selected view.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ledr_q <= '0;
    end else begin
      case (mode_q)
        2'd0:    ledr_q <= occ_row;
        2'd1:    ledr_q <= occ_col;
        2'd2:    ledr_q <= occ_blk;
        default: ledr_q <= '0;
      endcase
    end
  end

  assign view_mode  = mode_q;
  assign ledr       = ledr_q;
  assign hex_status = status_q;
  assign hex_row    = glyph(4'(row_q));
  assign hex_col    = glyph(4'(col_q));

endmodule
